// File: rtl/vm_protocol_checker.sv
// vm_protocol_checker
//   Passive monitor for a vending-machine product handshake. A request
//   (product_ready) opens a transaction; product_valid must follow within
//   MIN_LAT..MAX_LAT cycles while busy stays high. Rule violations are
//   reported as registered one-cycle pulses, sticky flags and a saturating
//   error count; legal transactions are counted in pass_cnt.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   en             checking enable; low forces IDLE and freezes counters/flags
//   clr            synchronous clear of err_sticky, err_cnt, pass_cnt
//   product_ready  request from the machine
//   product_valid  product delivered
//   busy           must stay high while a transaction is pending
//   change_valid   change is valid
//   no_change      machine reports "no change"; illegal without change_valid
//   irq_mask[5:0]  per-rule interrupt enable
//   viol[5:0]      one-cycle violation pulses (cycle after detection)
//   err_sticky     sticky violation flags
//   err_cnt        saturating violation count (popcount per cycle)
//   pass_cnt       saturating count of legal transactions
//   irq            |(err_sticky & irq_mask)
//
// Rule bits: 0 TIMEOUT, 1 EARLY, 2 BUSY, 3 OVERLAP, 4 SPURIOUS, 5 CHANGE.
//
// Handshake: product_ready seen in IDLE (or on a completing cycle) opens a
// transaction; lat is 1 in the first cycle after the request and counts up
// by one per cycle until product_valid or the MAX_LAT timeout closes it.
module vm_protocol_checker #(
   parameter int MIN_LAT = 1,
   parameter int MAX_LAT = 4,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             product_ready,
   input  logic             product_valid,
   input  logic             busy,
   input  logic             change_valid,
   input  logic             no_change,
   input  logic [5:0]       irq_mask,
   output logic [5:0]       viol,
   output logic [5:0]       err_sticky,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] pass_cnt,
   output logic             irq
);

   generate
      if (MIN_LAT < 1 || MIN_LAT > MAX_LAT || MAX_LAT > 255) begin : g_bad_lat
         $error("vm_protocol_checker: need 1 <= MIN_LAT <= MAX_LAT <= 255");
      end
      if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt
         $error("vm_protocol_checker: need 2 <= CNT_W <= 32");
      end
   endgenerate

   localparam int LAT_W = $clog2(MAX_LAT + 1);
   localparam int SUM_W = CNT_W + 3;

   localparam logic [LAT_W-1:0] MIN_L = LAT_W'(MIN_LAT);
   localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);
   localparam logic [LAT_W-1:0] ONE_L = LAT_W'(1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   localparam logic [SUM_W-1:0] CNT_MAX = {3'b000, {CNT_W{1'b1}}};

   logic [0:0]       state, state_n;
   logic [LAT_W-1:0] lat, lat_n;
   logic             busy_flag, busy_flag_n;   // BUSY already reported this txn
   logic [5:0]       det;
   logic             pass_evt;
   logic             complete;

   always_comb begin
      state_n     = state;
      lat_n       = lat;
      busy_flag_n = busy_flag;
      det         = '0;
      pass_evt    = 1'b0;
      complete    = 1'b0;
      if (!en) begin
         state_n     = S_IDLE;
         lat_n       = '0;
         busy_flag_n = 1'b0;
      end else begin
         if (no_change && !change_valid) det[5] = 1'b1;
         if (state == S_IDLE) begin
            if (product_valid) det[4] = 1'b1;
            if (product_ready) begin
               state_n     = S_WAIT;
               lat_n       = ONE_L;
               busy_flag_n = 1'b0;
            end
         end else begin
            if (!busy && !busy_flag) begin
               det[2]      = 1'b1;
               busy_flag_n = 1'b1;
            end
            if (product_valid) begin
               complete = 1'b1;
               if (lat < MIN_L) det[1] = 1'b1;
               else             pass_evt = 1'b1;
            end else if (lat == MAX_L) begin
               det[0]   = 1'b1;
               complete = 1'b1;
            end
            if (complete) begin
               // A request on the closing cycle starts the next transaction.
               if (product_ready) begin
                  state_n     = S_WAIT;
                  lat_n       = ONE_L;
                  busy_flag_n = 1'b0;
               end else begin
                  state_n     = S_IDLE;
                  lat_n       = '0;
                  busy_flag_n = 1'b0;
               end
            end else begin
               // Overlapping request is dropped; the pending one keeps counting.
               if (product_ready) det[3] = 1'b1;
               lat_n = lat + ONE_L;
            end
         end
      end
   end

   logic [2:0]       det_pop;
   logic [CNT_W-1:0] err_base, pass_base;
   logic [SUM_W-1:0] err_sum, pass_sum;

   always_comb begin
      det_pop = '0;
      for (int i = 0; i < 6; i++) det_pop = det_pop + {2'b00, det[i]};
   end

   // clr zeroes the base, this cycle's events are then added on top.
   assign err_base  = clr ? '0 : err_cnt;
   assign pass_base = clr ? '0 : pass_cnt;
   assign err_sum   = {3'b000, err_base}  + {{(SUM_W-3){1'b0}}, det_pop};
   assign pass_sum  = {3'b000, pass_base} + {{(SUM_W-1){1'b0}}, pass_evt};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         lat        <= '0;
         busy_flag  <= 1'b0;
         viol       <= '0;
         err_sticky <= '0;
         err_cnt    <= '0;
         pass_cnt   <= '0;
      end else begin
         state     <= state_n;
         lat       <= lat_n;
         busy_flag <= busy_flag_n;
         viol      <= det;
         if (en) begin
            err_sticky <= (clr ? 6'b000000 : err_sticky) | det;
            err_cnt    <= (err_sum  > CNT_MAX) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
            pass_cnt   <= (pass_sum > CNT_MAX) ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
         end
      end
   end

   assign irq = |(err_sticky & irq_mask);

endmodule

// File: tb/tb_vm_protocol_checker.sv
// Testbench for vm_protocol_checker (MIN_LAT=1, MAX_LAT=4, CNT_W=8).
// A table of single-transaction scenarios is replayed in a loop, followed by
// hand-written sequences for back-to-back requests, timeout pulse timing,
// clear-with-event, saturation/irq, enable gating and mid-transaction reset.
module tb_vm_protocol_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       clr = 1'b0;
   logic       product_ready = 1'b0;
   logic       product_valid = 1'b0;
   logic       busy = 1'b1;
   logic       change_valid = 1'b0;
   logic       no_change = 1'b0;
   logic [5:0] irq_mask = 6'b000000;
   logic [5:0] viol;
   logic [5:0] err_sticky;
   logic [7:0] err_cnt;
   logic [7:0] pass_cnt;
   logic       irq;

   int tests = 0;
   int fails = 0;
   logic [5:0] pulse_vec;   // OR of every viol pulse since last reset of it

   vm_protocol_checker #(.MIN_LAT(1), .MAX_LAT(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr),
      .product_ready(product_ready), .product_valid(product_valid),
      .busy(busy), .change_valid(change_valid), .no_change(no_change),
      .irq_mask(irq_mask), .viol(viol), .err_sticky(err_sticky),
      .err_cnt(err_cnt), .pass_cnt(pass_cnt), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle: drive on the falling edge, sample 1 time unit after rising.
   task automatic step(input logic rdy, input logic vld, input logic bsy,
                       input logic nc, input logic cl);
      @(negedge clk);
      product_ready = rdy;
      product_valid = vld;
      busy          = bsy;
      no_change     = nc;
      clr           = cl;
      @(posedge clk);
      #1;
      pulse_vec = pulse_vec | viol;
   endtask

   typedef struct {
      string      name;
      int         valid_at;   // cycle of product_valid, 0 = never
      int         ready2_at;  // cycle of a second request, 0 = none
      logic [7:0] busy_low;   // bit k: busy low in cycle Tk
      logic [5:0] exp_sticky;
      logic [7:0] exp_err;
      logic [7:0] exp_pass;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{"pass_t2",      2, 0, 8'h00, 6'b000000, 8'd0, 8'd1};
      vecs[1] = '{"pass_t1_min",  1, 0, 8'h00, 6'b000000, 8'd0, 8'd1};
      vecs[2] = '{"pass_t4_max",  4, 0, 8'h00, 6'b000000, 8'd0, 8'd1};
      vecs[3] = '{"late_t5",      5, 0, 8'h00, 6'b010001, 8'd2, 8'd0};
      vecs[4] = '{"timeout",      0, 0, 8'h00, 6'b000001, 8'd1, 8'd0};
      vecs[5] = '{"busy_overlap", 3, 2, 8'h02, 6'b001100, 8'd2, 8'd1};
      vecs[6] = '{"busy_once",    3, 0, 8'h06, 6'b000100, 8'd1, 8'd1};
      vecs[7] = '{"busy_idle_ok", 2, 0, 8'h01, 6'b000000, 8'd0, 8'd1};

      pulse_vec = '0;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_viol", {26'd0, viol}, 32'd0);
      check("rst_sticky", {26'd0, err_sticky}, 32'd0);
      check("rst_err", {24'd0, err_cnt}, 32'd0);
      check("rst_pass", {24'd0, pass_cnt}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven single transactions
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 1, 0, 1);
         pulse_vec = '0;
         step(1, 0, !vecs[i].busy_low[0], 0, 0);
         for (int k = 1; k < 8; k++)
            step(k == vecs[i].ready2_at, k == vecs[i].valid_at,
                 !vecs[i].busy_low[k], 0, 0);
         step(0, 0, 1, 0, 0);
         check({vecs[i].name, "_sticky"}, {26'd0, err_sticky}, {26'd0, vecs[i].exp_sticky});
         check({vecs[i].name, "_pulses"}, {26'd0, pulse_vec}, {26'd0, vecs[i].exp_sticky});
         check({vecs[i].name, "_err"}, {24'd0, err_cnt}, {24'd0, vecs[i].exp_err});
         check({vecs[i].name, "_pass"}, {24'd0, pass_cnt}, {24'd0, vecs[i].exp_pass});
      end

      // Back-to-back: valid+ready at T3 closes and reopens, valid at T5 passes
      step(0, 0, 1, 0, 1);
      pulse_vec = '0;
      step(1, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(1, 1, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      repeat (6) step(0, 0, 1, 0, 0);
      check("b2b_pass", {24'd0, pass_cnt}, 32'd2);
      check("b2b_pulses", {26'd0, pulse_vec}, 32'd0);

      // Timeout pulse lands exactly in T5 and lasts one cycle
      step(0, 0, 1, 0, 1);
      step(1, 0, 1, 0, 0);
      repeat (3) step(0, 0, 1, 0, 0);
      check("to_before_t5", {26'd0, viol}, 32'd0);
      step(0, 0, 1, 0, 0);
      check("to_pulse_t5", {26'd0, viol}, 32'd1);
      step(0, 0, 1, 0, 0);
      check("to_after_t5", {26'd0, viol}, 32'd0);
      check("to_sticky", {26'd0, err_sticky}, 32'd1);
      check("to_err", {24'd0, err_cnt}, 32'd1);

      // clr together with a CHANGE event keeps the new event
      step(0, 0, 1, 1, 1);
      check("clr_chg_err", {24'd0, err_cnt}, 32'd1);
      check("clr_chg_sticky", {26'd0, err_sticky}, 32'h20);

      // en=0 holds counters and suppresses detection
      en = 1'b0;
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 0, 0);
      check("en0_err_hold", {24'd0, err_cnt}, 32'd1);
      check("en0_viol", {26'd0, viol}, 32'd0);
      en = 1'b1;
      pulse_vec = '0;
      step(1, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      en = 1'b0;
      step(0, 0, 1, 0, 0);
      en = 1'b1;
      repeat (6) step(0, 0, 1, 0, 0);
      check("en0_abort_pulses", {26'd0, pulse_vec}, 32'd0);
      check("en0_abort_err", {24'd0, err_cnt}, 32'd1);

      // Saturation and irq masking
      repeat (300) step(0, 0, 1, 1, 0);
      step(0, 0, 1, 0, 0);
      check("sat_err", {24'd0, err_cnt}, 32'd255);
      irq_mask = 6'b100000;
      #1;
      check("irq_on", {31'd0, irq}, 32'd1);
      irq_mask = 6'b011111;
      #1;
      check("irq_masked", {31'd0, irq}, 32'd0);
      irq_mask = 6'b100000;

      // Reset in the middle of a transaction (lat=2)
      step(1, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      check("mrst_viol", {26'd0, viol}, 32'd0);
      check("mrst_sticky", {26'd0, err_sticky}, 32'd0);
      check("mrst_err", {24'd0, err_cnt}, 32'd0);
      check("mrst_pass", {24'd0, pass_cnt}, 32'd0);
      check("mrst_irq", {31'd0, irq}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pulse_vec = '0;
      repeat (8) step(0, 0, 1, 0, 0);
      check("mrst_no_timeout", {26'd0, pulse_vec}, 32'd0);
      check("mrst_err_after", {24'd0, err_cnt}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
